phase_sequencer: RTL and testbench

- Sequences the two-group traffic-light datapath through green/yellow phases.
- Owns the per-phase countdown.
- Arbitrates asynchronous green requests from both groups (pedestrian/priority buttons) by truncating the conflicting green once a minimum green has elapsed.
- Sits between the key/mode decode and the lamp-decode and seven-segment display logic. Outputs phase code, remaining seconds and grant pulses.

---
 rtl/phase_sequencer_pkg.sv | 33 +++
 rtl/phase_sequencer_timer.sv | 42 ++++
 rtl/phase_sequencer.sv | 119 +++++++++++
 tb/tb_phase_sequencer.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/phase_sequencer_pkg.sv
// Shared phase encodings, default times and phase-order helpers for the
// two-group traffic-light sequencer.
package phase_sequencer_pkg;

    typedef enum logic [2:0] {
        PH_NIGHT = 3'd0,
        PH_G1    = 3'd1,
        PH_Y1    = 3'd2,
        PH_G2    = 3'd3,
        PH_Y2    = 3'd4
    } phase_t;

    localparam int DEF_RG_TIME   = 30;
    localparam int DEF_Y_TIME    = 5;
    localparam int DEF_MIN_GREEN = 5;

    // NIGHT exits into G1; the day cycle is G1 -> Y1 -> G2 -> Y2 -> G1.
    function automatic phase_t next_phase(input phase_t ph);
        phase_t nxt;
        case (ph)
            PH_G1:   nxt = PH_Y1;
            PH_Y1:   nxt = PH_G2;
            PH_G2:   nxt = PH_Y2;
            default: nxt = PH_G1;
        endcase
        return nxt;
    endfunction

    function automatic logic is_green(input phase_t ph);
        return (ph == PH_G1) || (ph == PH_G2);
    endfunction

endpackage

// File: rtl/phase_sequencer_timer.sv
// Per-phase down-counter: load, tick-enabled decrement, and elapsed time
// measured against the value captured at the last load.
module phase_timer
    import phase_sequencer_pkg::*;
#(
    parameter int CNT_W = 11
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic [CNT_W-1:0] remain,
    output logic             zero,
    output logic [CNT_W-1:0] elapsed
);

    logic [CNT_W-1:0] remain_reg;
    logic [CNT_W-1:0] loaded_reg;

    // clear beats load, load beats decrement; a zero count never wraps.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            remain_reg <= '0;
            loaded_reg <= '0;
        end else if (clear) begin
            remain_reg <= '0;
            loaded_reg <= '0;
        end else if (load) begin
            remain_reg <= load_val;
            loaded_reg <= load_val;
        end else if (dec && (remain_reg != '0)) begin
            remain_reg <= remain_reg - 1'b1;
        end
    end

    assign remain  = remain_reg;
    assign zero    = (remain_reg == '0);
    assign elapsed = loaded_reg - remain_reg;

endmodule

// File: rtl/phase_sequencer.sv
// Two-group green/yellow phase sequencer with request latching, minimum-green
// truncation of the conflicting green, and forced night mode.
module phase_sequencer
    import phase_sequencer_pkg::*;
#(
    parameter int CNT_W     = 11,
    parameter int MIN_GREEN = DEF_MIN_GREEN,
    parameter int PH_W      = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             tick,
    input  logic             run,
    input  logic             night,
    input  logic [CNT_W-1:0] rg_time,
    input  logic [CNT_W-1:0] y_time,
    input  logic             req1,
    input  logic             req2,
    output logic [PH_W-1:0]  phase,
    output logic [CNT_W-1:0] remain,
    output logic             phase_start,
    output logic             grant1,
    output logic             grant2,
    output logic [1:0]       pending
);

    phase_t           phase_reg;
    logic             start_reg;
    logic             grant1_reg;
    logic             grant2_reg;
    logic             pend1_reg;
    logic             pend2_reg;

    logic [CNT_W-1:0] rg_eff;
    logic [CNT_W-1:0] y_eff;
    logic [CNT_W-1:0] load_val;
    logic [CNT_W-1:0] elapsed;
    logic             timer_zero;
    logic             trunc_req;
    logic             trunc_go;
    logic             advance;
    logic             load;
    logic             pend1_next;
    logic             pend2_next;
    phase_t           next_ph;

    assign rg_eff = (rg_time == '0) ? CNT_W'(1) : rg_time;
    assign y_eff  = (y_time == '0) ? CNT_W'(1) : y_time;

    assign trunc_req = ((phase_reg == PH_G1) && pend2_reg) ||
                       ((phase_reg == PH_G2) && pend1_reg);
    // With loaded_green <= MIN_GREEN, elapsed can only reach MIN_GREEN at
    // remain == 0, where truncation and the natural end coincide.
    assign trunc_go = trunc_req && (elapsed >= CNT_W'(MIN_GREEN));

    assign advance  = run && (phase_reg != PH_NIGHT) && (timer_zero || trunc_go);
    assign load     = !night && run && ((phase_reg == PH_NIGHT) || advance);
    assign next_ph  = next_phase(phase_reg);
    assign load_val = is_green(next_ph) ? rg_eff : y_eff;

    always_comb begin
        pend1_next = pend1_reg | req1;
        pend2_next = pend2_reg | req2;
        if ((phase_reg == PH_NIGHT) || (phase_reg == PH_G1) || (load && next_ph == PH_G1))
            pend1_next = 1'b0;
        if ((phase_reg == PH_NIGHT) || (phase_reg == PH_G2) || (load && next_ph == PH_G2))
            pend2_next = 1'b0;
    end

    phase_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (night),
        .load     (load),
        .load_val (load_val),
        .dec      (tick && run && !night),
        .remain   (remain),
        .zero     (timer_zero),
        .elapsed  (elapsed)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_reg  <= PH_NIGHT;
            start_reg  <= 1'b0;
            grant1_reg <= 1'b0;
            grant2_reg <= 1'b0;
            pend1_reg  <= 1'b0;
            pend2_reg  <= 1'b0;
        end else begin
            start_reg  <= 1'b0;
            grant1_reg <= 1'b0;
            grant2_reg <= 1'b0;
            if (night) begin
                phase_reg <= PH_NIGHT;
                pend1_reg <= 1'b0;
                pend2_reg <= 1'b0;
            end else begin
                if (load) begin
                    phase_reg  <= next_ph;
                    start_reg  <= 1'b1;
                    grant1_reg <= (next_ph == PH_G1) && pend1_reg;
                    grant2_reg <= (next_ph == PH_G2) && pend2_reg;
                end
                pend1_reg <= pend1_next;
                pend2_reg <= pend2_next;
            end
        end
    end

    assign phase       = PH_W'(phase_reg);
    assign phase_start = start_reg;
    assign grant1      = grant1_reg;
    assign grant2      = grant2_reg;
    assign pending     = {pend2_reg, pend1_reg};

endmodule

// File: tb/tb_phase_sequencer.sv
// Table-driven and sequence checks of phase_sequencer through a scoreboard
// queue of expected output records.
module tb_phase_sequencer;

    localparam int NI = 0, G1 = 1, Y1 = 2, G2 = 3, Y2 = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        tick = 1'b0, run = 1'b0, night = 1'b0, req1 = 1'b0, req2 = 1'b0;
    logic [10:0] rg_time = 11'd3, y_time = 11'd2;
    logic [2:0]  phase;
    logic [10:0] remain;
    logic        phase_start, grant1, grant2;
    logic [1:0]  pending;

    phase_sequencer #(.CNT_W(11), .MIN_GREEN(5), .PH_W(3)) dut (
        .clk(clk), .rst_n(rst_n), .tick(tick), .run(run), .night(night),
        .rg_time(rg_time), .y_time(y_time), .req1(req1), .req2(req2),
        .phase(phase), .remain(remain), .phase_start(phase_start),
        .grant1(grant1), .grant2(grant2), .pending(pending)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0]  ph;
        logic [10:0] rem;
        logic        ps;
        logic        g1;
        logic        g2;
        logic [1:0]  pd;
    } exp_t;

    typedef struct {
        bit   tk, r1, r2, nt, rn;
        exp_t e;
    } vec_t;

    exp_t  sb[$];
    string nm_q[$];
    int    total = 0;
    int    bad = 0;
    vec_t  tbl[20];

    function automatic exp_t mk(input int ph, input int rem, input bit ps,
                                input bit g1, input bit g2, input int pd);
        exp_t e;
        e.ph  = 3'(ph);
        e.rem = 11'(rem);
        e.ps  = ps;
        e.g1  = g1;
        e.g2  = g2;
        e.pd  = 2'(pd);
        return e;
    endfunction

    task automatic check_out();
        exp_t  e, a;
        string n;
        e = sb.pop_front();
        n = nm_q.pop_front();
        a = {phase, remain, phase_start, grant1, grant2, pending};
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s: got ph=%0d rem=%0d ps=%0b g1=%0b g2=%0b pd=%b, want ph=%0d rem=%0d ps=%0b g1=%0b g2=%0b pd=%b",
                     n, a.ph, a.rem, a.ps, a.g1, a.g2, a.pd, e.ph, e.rem, e.ps, e.g1, e.g2, e.pd);
        end else begin
            $display("ok   %s: ph=%0d rem=%0d ps=%0b g1=%0b g2=%0b pd=%b",
                     n, a.ph, a.rem, a.ps, a.g1, a.g2, a.pd);
        end
    endtask

    task automatic st(input bit tk, input bit r1, input bit r2, input bit nt, input bit rn,
                      input exp_t e, input string n);
        tick = tk; req1 = r1; req2 = r2; night = nt; run = rn;
        sb.push_back(e);
        nm_q.push_back(n);
        @(posedge clk);
        #1;
        tick = 1'b0; req1 = 1'b0; req2 = 1'b0;
        check_out();
    endtask

    initial begin
        // Nominal cycle with rg=3, y=2, then own-green request and night.
        tbl[0]  = '{0, 0, 0, 0, 1, mk(G1, 3, 1, 0, 0, 0)};
        tbl[1]  = '{1, 0, 0, 0, 1, mk(G1, 2, 0, 0, 0, 0)};
        tbl[2]  = '{0, 0, 0, 0, 1, mk(G1, 2, 0, 0, 0, 0)};
        tbl[3]  = '{1, 0, 0, 0, 1, mk(G1, 1, 0, 0, 0, 0)};
        tbl[4]  = '{1, 0, 0, 0, 1, mk(G1, 0, 0, 0, 0, 0)};
        tbl[5]  = '{0, 0, 0, 0, 1, mk(Y1, 2, 1, 0, 0, 0)};
        tbl[6]  = '{1, 0, 0, 0, 1, mk(Y1, 1, 0, 0, 0, 0)};
        tbl[7]  = '{1, 0, 0, 0, 1, mk(Y1, 0, 0, 0, 0, 0)};
        tbl[8]  = '{1, 0, 0, 0, 1, mk(G2, 3, 1, 0, 0, 0)};
        tbl[9]  = '{1, 0, 0, 0, 1, mk(G2, 2, 0, 0, 0, 0)};
        tbl[10] = '{1, 0, 0, 0, 1, mk(G2, 1, 0, 0, 0, 0)};
        tbl[11] = '{1, 0, 0, 0, 1, mk(G2, 0, 0, 0, 0, 0)};
        tbl[12] = '{0, 0, 0, 0, 1, mk(Y2, 2, 1, 0, 0, 0)};
        tbl[13] = '{1, 0, 0, 0, 1, mk(Y2, 1, 0, 0, 0, 0)};
        tbl[14] = '{1, 0, 0, 0, 1, mk(Y2, 0, 0, 0, 0, 0)};
        tbl[15] = '{0, 0, 0, 0, 1, mk(G1, 3, 1, 0, 0, 0)};
        tbl[16] = '{0, 1, 0, 0, 1, mk(G1, 3, 0, 0, 0, 0)};
        tbl[17] = '{0, 0, 0, 1, 1, mk(NI, 0, 0, 0, 0, 0)};
        tbl[18] = '{0, 1, 0, 1, 1, mk(NI, 0, 0, 0, 0, 0)};
        tbl[19] = '{0, 0, 0, 0, 0, mk(NI, 0, 0, 0, 0, 0)};

        repeat (2) @(posedge clk);
        #1;
        sb.push_back(mk(NI, 0, 0, 0, 0, 0));
        nm_q.push_back("reset");
        check_out();
        @(negedge clk);
        rst_n = 1'b1;

        foreach (tbl[i])
            st(tbl[i].tk, tbl[i].r1, tbl[i].r2, tbl[i].nt, tbl[i].rn, tbl[i].e,
               $sformatf("tbl_%0d", i));

        // Truncation of G1 by req2 after MIN_GREEN, then served by G2.
        rg_time = 11'd30; y_time = 11'd5;
        st(0, 0, 0, 0, 1, mk(G1, 30, 1, 0, 0, 0), "a_load");
        st(1, 0, 0, 0, 1, mk(G1, 29, 0, 0, 0, 0), "a_t1");
        st(1, 0, 0, 0, 1, mk(G1, 28, 0, 0, 0, 0), "a_t2");
        st(0, 0, 1, 0, 1, mk(G1, 28, 0, 0, 0, 2), "a_req2");
        for (int i = 1; i <= 3; i++)
            st(1, 0, 0, 0, 1, mk(G1, 28 - i, 0, 0, 0, 2), $sformatf("a_g1_%0d", 28 - i));
        st(0, 0, 0, 0, 1, mk(Y1, 5, 1, 0, 0, 2), "a_trunc");
        for (int i = 1; i <= 5; i++)
            st(1, 0, 0, 0, 1, mk(Y1, 5 - i, 0, 0, 0, 2), $sformatf("a_y1_%0d", 5 - i));
        st(0, 0, 0, 0, 1, mk(G2, 30, 1, 0, 1, 0), "a_grant2");

        // Own-green request, hold with requests latching, truncation of G2.
        st(0, 0, 1, 0, 1, mk(G2, 30, 0, 0, 0, 0), "b_own_req");
        for (int i = 1; i <= 23; i++)
            st(1, 0, 0, 0, 1, mk(G2, 30 - i, 0, 0, 0, 0), $sformatf("b_g2_%0d", 30 - i));
        for (int i = 0; i < 50; i++)
            st(1, (i == 10), 0, 0, 0, mk(G2, 7, 0, 0, 0, (i >= 10) ? 1 : 0),
               $sformatf("b_hold_%0d", i));
        st(0, 0, 0, 0, 1, mk(Y2, 5, 1, 0, 0, 1), "b_trunc");
        for (int i = 1; i <= 5; i++)
            st(1, 0, 0, 0, 1, mk(Y2, 5 - i, 0, 0, 0, 1), $sformatf("b_y2_%0d", 5 - i));
        st(0, 0, 0, 0, 1, mk(G1, 30, 1, 1, 0, 0), "b_grant1");

        // Both requests latched in Y1.
        st(0, 0, 1, 0, 1, mk(G1, 30, 0, 0, 0, 2), "c_req2");
        for (int i = 1; i <= 5; i++)
            st(1, 0, 0, 0, 1, mk(G1, 30 - i, 0, 0, 0, 2), $sformatf("c_g1_%0d", 30 - i));
        st(0, 0, 0, 0, 1, mk(Y1, 5, 1, 0, 0, 2), "c_y1");
        st(0, 1, 1, 0, 1, mk(Y1, 5, 0, 0, 0, 3), "c_both_y");
        for (int i = 1; i <= 5; i++)
            st(1, 0, 0, 0, 1, mk(Y1, 5 - i, 0, 0, 0, 3), $sformatf("c_y1_%0d", 5 - i));
        st(0, 0, 0, 0, 1, mk(G2, 30, 1, 0, 1, 1), "c_grant2");
        for (int i = 1; i <= 5; i++)
            st(1, 0, 0, 0, 1, mk(G2, 30 - i, 0, 0, 0, 1), $sformatf("c_g2_%0d", 30 - i));
        st(0, 0, 0, 0, 1, mk(Y2, 5, 1, 0, 0, 1), "c_trunc");
        for (int i = 1; i <= 5; i++)
            st(1, 0, 0, 0, 1, mk(Y2, 5 - i, 0, 0, 0, 1), $sformatf("c_y2_%0d", 5 - i));
        st(0, 0, 0, 0, 1, mk(G1, 30, 1, 1, 0, 0), "c_grant1");
        st(0, 1, 1, 0, 1, mk(G1, 30, 0, 0, 0, 2), "c_both_g");
        st(0, 0, 0, 1, 1, mk(NI, 0, 0, 0, 0, 0), "c_night");

        // Zero times load as 1; async reset mid-Y2 drops pending.
        rg_time = 11'd0; y_time = 11'd0;
        st(0, 0, 0, 0, 1, mk(G1, 1, 1, 0, 0, 0), "d_g1");
        st(1, 0, 0, 0, 1, mk(G1, 0, 0, 0, 0, 0), "d_g1_0");
        st(0, 0, 0, 0, 1, mk(Y1, 1, 1, 0, 0, 0), "d_y1");
        st(1, 0, 0, 0, 1, mk(Y1, 0, 0, 0, 0, 0), "d_y1_0");
        st(0, 0, 0, 0, 1, mk(G2, 1, 1, 0, 0, 0), "d_g2");
        st(1, 0, 0, 0, 1, mk(G2, 0, 0, 0, 0, 0), "d_g2_0");
        st(0, 0, 0, 0, 1, mk(Y2, 1, 1, 0, 0, 0), "d_y2");
        st(0, 1, 0, 0, 1, mk(Y2, 1, 0, 0, 0, 1), "d_y2_req1");
        #3 rst_n = 1'b0;
        #1;
        sb.push_back(mk(NI, 0, 0, 0, 0, 0));
        nm_q.push_back("d_async_rst");
        check_out();
        @(posedge clk);
        #1;
        sb.push_back(mk(NI, 0, 0, 0, 0, 0));
        nm_q.push_back("d_rst_hold");
        check_out();
        rst_n = 1'b1;
        st(0, 0, 0, 0, 1, mk(G1, 1, 1, 0, 0, 0), "d_restart");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
